// File: rtl/mem_pkg.sv
// Shared access-size encoding and lane helpers for the data memory.
// The same helpers are used for store lane selection and load extraction.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE    = 2'd0,
    MEM_HALF    = 2'd1,
    MEM_WORD    = 2'd2,
    MEM_ILLEGAL = 2'd3
  } mem_size_e;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      MEM_BYTE: bad = 1'b0;
      MEM_HALF: bad = off[0];
      MEM_WORD: bad = |off;
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] mask;
    case (size)
      MEM_BYTE: mask = 4'b0001 << off;
      MEM_HALF: mask = 4'b0011 << off;
      MEM_WORD: mask = 4'b1111;
      default:  mask = 4'b0000;
    endcase
    return mask;
  endfunction

  function automatic logic [31:0] store_align(input logic [31:0] wdata, input logic [1:0] off);
    return wdata << {off, 3'b000};
  endfunction

  // Shift the addressed lanes down to bit 0, then sign- or zero-extend.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic [31:0] shifted;
    logic [31:0] result;
    shifted = word >> {off, 3'b000};
    case (size)
      MEM_BYTE: result = {{24{~uns & shifted[7]}}, shifted[7:0]};
      MEM_HALF: result = {{16{~uns & shifted[15]}}, shifted[15:0]};
      MEM_WORD: result = shifted;
      default:  result = 32'h0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTH x 32 storage with byte-enabled synchronous write and registered read.
// Contents are intentionally not reset.
module mem_array #(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [3:0]       i_be,
  input  logic             i_re,
  input  logic [IDX_W-1:0] i_addr,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    // Read data only moves on an accepted load, so a stalled response stays stable.
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem.sv
// Single-slot load/store data memory: request check, lane steering, one-deep
// response register with latency 1 and full back-to-back throughput.
module data_mem
  import mem_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_off;
  logic             w_oor;
  logic             w_err;
  logic             w_accept;
  logic             w_mem_we;
  logic             w_mem_re;
  logic [31:0]      w_rdata;

  logic             r_rsp_valid;
  logic             r_err;
  logic             r_load;
  logic [1:0]       r_size;
  logic [1:0]       r_off;
  logic             r_uns;

  assign w_idx = req_addr[IDX_W+1:2];
  assign w_off = req_addr[1:0];

  // 4*DEPTH is a power of two, so out-of-range is any set bit above the index.
  generate
    if (ADDR_W > IDX_W + 2) begin : g_oor
      assign w_oor = |req_addr[ADDR_W-1:IDX_W+2];
    end else begin : g_no_oor
      assign w_oor = 1'b0;
    end
  endgenerate

  assign w_err     = misaligned(req_size, w_off) | w_oor;
  assign req_ready = !r_rsp_valid || rsp_ready;
  assign w_accept  = req_valid && req_ready;
  assign w_mem_we  = w_accept && req_we && !w_err;
  assign w_mem_re  = w_accept && !req_we && !w_err;

  mem_array #(
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_mem_we),
    .i_be    (lane_mask(req_size, w_off)),
    .i_re    (w_mem_re),
    .i_addr  (w_idx),
    .i_wdata (store_align(req_wdata, w_off)),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      r_load      <= 1'b0;
      r_size      <= 2'd0;
      r_off       <= 2'd0;
      r_uns       <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_err       <= w_err;
      r_load      <= w_mem_re;
      r_size      <= req_size;
      r_off       <= w_off;
      r_uns       <= req_unsigned;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_valid & r_err;
  assign rsp_rdata = (r_rsp_valid && r_load) ? load_extend(w_rdata, r_size, r_off, r_uns) : 32'h0;

endmodule

// File: tb/tb_data_mem.sv
// Bench for data_mem: directed scenarios plus random traffic against a
// byte-array reference model with an in-order expected-response queue.
module tb_data_mem;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 32;
  localparam int NBYTES = 4 * DEPTH;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  data_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic [7:0] mdl [NBYTES];
  rsp_t       exp_q [$];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: error rules and little-endian byte storage computed directly.
  function automatic void model(input bit we, input logic [1:0] sz, input bit uns,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
    int n;
    n  = 1 << sz;
    er = (sz == 2'd3) || ((a % n) != 0) || (a >= NBYTES);
    rd = 32'h0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < n; i++) mdl[a + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) rd = rd | (32'(mdl[a + i]) << (8 * i));
        if (n < 4 && !uns && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8 * n));
      end
    end
  endfunction

  task automatic cyc(input bit v, input bit we, input logic [1:0] sz, input bit uns,
                     input logic [31:0] a, input logic [31:0] wd, input bit rr);
    rsp_t r;
    @(negedge clk);
    req_valid    = v;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    rsp_ready    = rr;
    #1;
    check("req_ready", 32'(req_ready), 32'(exp_q.size() == 0 || rr));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("rsp_rdata", rsp_rdata, exp_q[0].rdata);
      check("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
      if (rr) void'(exp_q.pop_front());
    end
    if (v && req_ready) begin
      model(we, sz, uns, a, wd, r.rdata, r.err);
      exp_q.push_back(r);
    end
  endtask

  task automatic idle(input bit rr);
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, rr);
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    rsp_ready    = 1'b1;
    for (int i = 0; i < NBYTES; i++) mdl[i] = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err", 32'(rsp_err), 32'h0);
    rst_n = 1'b1;

    // Fill memory with zeros so every later load has a known value.
    for (int w = 0; w < DEPTH; w++) cyc(1'b1, 1'b1, 2'd2, 1'b0, 32'(4 * w), 32'h0, 1'b1);

    cyc(1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1);
    cyc(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
    idle(1'b1);

    cyc(1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
    cyc(1'b1, 1'b1, 2'd0, 1'b0, 32'h11, 32'h80, 1'b1);
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);

    cyc(1'b1, 1'b1, 2'd1, 1'b0, 32'h13, 32'hFFFF, 1'b1);
    cyc(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 2'd2, 1'b0, 32'(NBYTES), 32'h0, 1'b1);
    cyc(1'b1, 1'b1, 2'd3, 1'b0, 32'h14, 32'h1234, 1'b1);
    cyc(1'b1, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b1);
    idle(1'b1);

    // Stall the response for three cycles while a request waits.
    cyc(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
    repeat (3) cyc(1'b1, 1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b0);
    repeat (4) cyc(1'b1, 1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 1'b1);
    idle(1'b1);

    cyc(1'b1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h1234_5678, 1'b1);
    cyc(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1);
    idle(1'b1);

    // Reset while a response is stalled; stores before the reset must persist.
    cyc(1'b1, 1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFE_F00D, 1'b1);
    cyc(1'b1, 1'b1, 2'd2, 1'b0, 32'h44, 32'h0BAD_CAFE, 1'b1);
    idle(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(rsp_valid), 32'h0);
    check("async_rst_rdata", rsp_rdata, 32'h0);
    check("async_rst_err", 32'(rsp_err), 32'h0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);
    idle(1'b1);
    cyc(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 1'b1);
    idle(1'b1);

    for (int k = 0; k < 3000; k++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = $urandom_range(NBYTES - 8, NBYTES + 40);
      else a = $urandom_range(0, NBYTES - 1);
      if ($urandom_range(0, 3) != 0) a = a & ~((32'h1 << sz) - 32'h1);
      cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
          a, $urandom, $urandom_range(0, 9) < 7);
    end
    repeat (2) idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 32-bit words (power of two, >=4).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when req_valid&&req_ready.
REQ-007 SHALL have port req_we  input  1  1=store, 0=load.
REQ-008 SHALL have port req_size  input  2  access size: 0=byte, 1=half, 2=word, 3=illegal.
REQ-009 SHALL have port req_unsigned  input  1  load zero-extend (1) or sign-extend (0).
REQ-010 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-011 SHALL have port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 SHALL have port rsp_valid  output  1  response present.
REQ-013 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-014 SHALL have port rsp_rdata  output  32  load result, extended; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  output  1  request was misaligned, out of range or illegal size.

Function
REQ-016 SHALL compute word index = req_addr[$clog2(DEPTH)+1:2], byte offset = req_addr[1:0].
REQ-017 SHALL flag error when: size=3; half with addr[0]=1; word with addr[1:0]!=0; req_addr >= 4*DEPTH.
REQ-018 SHALL, on accepted store without error, write only addressed lanes (byte: 1 lane at offset; half: 2 lanes at offset; word: all 4), little-endian.
REQ-019 SHALL NOT modify memory on any errored request.
REQ-020 SHALL, on accepted load, return addressed byte/half/word shifted to bit 0, sign- or zero-extended per req_unsigned (word ignores req_unsigned).
REQ-021 SHALL produce exactly one response per accepted request, in order, rsp_valid asserted the cycle after acceptance (latency 1).
REQ-022 SHALL hold rsp_valid, rsp_rdata, rsp_err stable while rsp_valid&&!rsp_ready.
REQ-023 SHALL drive req_ready = !rsp_valid || rsp_ready (single response slot; combinational, no path from req_valid).
REQ-024 SHALL, on simultaneous response handshake and request acceptance, replace the response slot with the new response in the next cycle (back-to-back throughput of 1/cycle).
REQ-025 SHALL return pre-write data when a load follows a store to the same word only if the store had not yet been accepted; a load accepted the cycle after a store SHALL see the stored data.
REQ-026 SHALL ignore req_* when req_valid=0; rsp_valid SHALL fall the cycle after handshake if no new request accepted.

Reset
REQ-027 SHALL, while rst_n=0, force rsp_valid=0, rsp_err=0, rsp_rdata=0 immediately (asynchronous).
REQ-028 SHALL NOT reset memory contents; a request in flight at reset assertion SHALL be dropped without response, and any store accepted before reset edge remains written.
REQ-029 SHALL accept requests in the first cycle after rst_n deasserts (req_ready=1).

Structure
REQ-030 SHALL place the access-size enum (MEM_BYTE, MEM_HALF, MEM_WORD) and lane-mask/extension helper functions in shared package mem_pkg.
REQ-031 SHALL instantiate one sub-module mem_array: DEPTH x 32 storage, synchronous write with 4-bit byte enable, synchronous read; no reset.
REQ-032 SHALL keep alignment check, lane steering and response slot in data_mem.

Verification
REQ-033 SHALL test store word 0xDEADBEEF @0x10, load word @0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, latency 1.
REQ-034 SHALL test store byte 0x80 @0x11 over 0x00000000, load byte signed @0x11 -> 0xFFFFFF80; unsigned -> 0x00000080; load word @0x10 -> 0x00008000.
REQ-035 SHALL test store half @0x13 -> rsp_err=1, memory unchanged; load word @0x4*DEPTH -> rsp_err=1, rsp_rdata=0; size=3 -> rsp_err=1.
REQ-036 SHALL test rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, response held stable, no second request accepted; release -> 1 response/cycle thereafter.
REQ-037 SHALL test back-to-back store 0x12345678 @0x20 then load @0x20 next cycle -> 0x12345678.
REQ-038 SHALL test rst_n low while rsp_valid=1 and rsp_ready=0 -> rsp_valid=0 immediately, no response after release, stored data retained.
